// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with signed/unsigned modes and divide-by-zero detection.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        MUL_ITER,
        DIV_ITER,
        FIXUP,
        DONE
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic               neg_q;
    logic               neg_r;
    logic               op_div;
    logic               dz;
    logic [CW-1:0]      cnt;

    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH+1:0]   trial;
    logic               take;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               last_iter;

    // Magnitudes stay WIDTH-bit unsigned so |MIN_INT| needs no extra bit.
    always_comb begin
        sa        = is_signed & op_a[WIDTH-1];
        sb        = is_signed & op_b[WIDTH-1];
        mag_a     = sa ? (~op_a + 1'b1) : op_a;
        mag_b     = sb ? (~op_b + 1'b1) : op_b;
        add_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
        trial     = {rem, quo[WIDTH-1]} - {2'b00, opnd};
        take      = ~trial[WIDTH+1];
        prod_fix  = neg_q ? (~prod + 1'b1) : prod;
        quo_fix   = neg_q ? (~quo + 1'b1) : quo;
        rem_fix   = neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign div_zero = (state == DONE) && dz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            prod   <= '0;
            opnd   <= '0;
            rem    <= '0;
            quo    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            op_div <= 1'b0;
            dz     <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dz <= 1'b0;
                    if (mult_start) begin
                        opnd   <= mag_a;
                        prod   <= {{WIDTH{1'b0}}, mag_b};
                        neg_q  <= sa ^ sb;
                        neg_r  <= 1'b0;
                        op_div <= 1'b0;
                        cnt    <= '0;
                        state  <= MUL_ITER;
                    end else if (div_start) begin
                        if (op_b == '0) begin
                            dz    <= 1'b1;
                            state <= DONE;
                        end else begin
                            opnd   <= mag_b;
                            quo    <= mag_a;
                            rem    <= '0;
                            neg_q  <= sa ^ sb;
                            neg_r  <= sa;
                            op_div <= 1'b1;
                            cnt    <= '0;
                            state  <= DIV_ITER;
                        end
                    end
                end
                MUL_ITER: begin
                    // Add into the upper half, then shift the whole register right.
                    prod <= {add_sum, prod[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (last_iter) state <= FIXUP;
                end
                DIV_ITER: begin
                    rem <= take ? trial[WIDTH:0] : {rem[WIDTH-1:0], quo[WIDTH-1]};
                    quo <= {quo[WIDTH-2:0], take};
                    cnt <= cnt + 1'b1;
                    if (last_iter) state <= FIXUP;
                end
                FIXUP: begin
                    if (op_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed plus random checks of muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         mult_start;
    logic         div_start;
    logic         is_signed;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;
    logic [2*W:0] exp_q[$];

    muldiv_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .is_signed  (is_signed),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {div_zero, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [2*W:0] model(input bit m, input bit sgn,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa;
        longint       sb;
        logic [63:0]  p;
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (m) begin
            if (sgn) p = longint'($signed(a)) * longint'($signed(b));
            else     p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (b == '0) return {1'b1, prev_hi, prev_lo};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {1'b0, r, q};
    endfunction

    task automatic run_op(input bit m, input bit d, input bit sgn,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
        logic [2*W:0] e;
        int           lat;
        int           k;
        bit           busy_ok;
        bit           hold_ok;
        @(negedge clk);
        mult_start = m;
        div_start  = d;
        is_signed  = sgn;
        op_a       = a;
        op_b       = b;
        exp_q.push_back(model(m, sgn, a, b));
        lat = (!m && b == '0) ? 1 : W + 2;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        k = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            mult_start = 1'b0;
            if (done) begin
                k = c;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
            op_a = $urandom;
            op_b = $urandom;
            if (c == poke) mult_start = 1'b1;
        end
        e = exp_q.pop_front();
        check("latency", W'(k), W'(lat));
        check("busy_while_running", W'(busy_ok), 1);
        check("hold_while_busy", W'(hold_ok), 1);
        check("busy_at_done", W'(busy), 1);
        check("div_zero", W'(div_zero), W'(e[2*W]));
        check("hi", hi, e[2*W-1:W]);
        check("lo", lo, e[W-1:0]);
        prev_hi = e[2*W-1:W];
        prev_lo = e[W-1:0];
        @(negedge clk);
        check("done_clears", W'(done), 0);
        check("idle_after_done", W'(busy), 0);
    endtask

    initial begin
        bit           rm;
        bit           rs;
        bit           nodone;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        is_signed  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", W'(busy), 0);
        check("reset_done", W'(done), 0);
        check("reset_div_zero", W'(div_zero), 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        reset = 1'b0;

        run_op(1, 0, 0, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        run_op(1, 0, 1, 32'hFFFF_FFF9, 32'h0000_0006, 4);
        run_op(0, 1, 1, 32'hFFFF_FFEF, 32'h0000_0005, 0);
        run_op(0, 1, 0, 32'hFFFF_FFEF, 32'h0000_0005, 0);
        run_op(1, 0, 0, 32'h0000_0022, 32'h8000_0001, 0);
        run_op(0, 1, 0, 32'h1234_5678, 32'h0000_0000, 0);
        run_op(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1, 1, 0, 32'h0000_0003, 32'h0000_0004, 0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        mult_start = 1'b1;
        is_signed  = 1'b0;
        op_a       = 32'h0000_1234;
        op_b       = 32'h0000_5678;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_busy", W'(busy), 0);
        check("midreset_done", W'(done), 0);
        check("midreset_hi", hi, 0);
        check("midreset_lo", lo, 0);
        @(negedge clk);
        reset   = 1'b0;
        prev_hi = '0;
        prev_lo = '0;
        nodone  = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) nodone = 1'b0;
        end
        check("no_done_after_reset", W'(nodone), 1);
        run_op(1, 0, 0, 32'h0000_0003, 32'h0000_0003, 0);

        for (int i = 0; i < 24; i++) begin
            rm = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(rm, !rm, rs, ra, rb, (i % 3 == 0) ? 7 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
